// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O register block for the RV32I LSU I/O window.
// Drives red/green LEDs, 7-segment digits and the LCD register, and samples
// the switches through a 2-flop synchroniser with an optional debounce stage.
// A sticky IRQ flag reports changes of the debounced switch value.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req/i_we/i_addr/i_be/i_wdata   access request (one per cycle, no stall)
//   o_ack/o_err/o_rdata   registered response, valid the cycle after i_req
//   o_io_ledr/ledg/hex/lcd  output registers (hex segments active-low)
//   o_sw_irq              sticky switch-change flag (STAT bit0, W1C)
//   i_io_sw               asynchronous switch inputs
//
// Build option: define IO_DEBOUNCE_EN to add a DEB_CYCLES stable-count debounce
// between the synchroniser and the debounced switch register.
module mmio_io_ctrl #(
  parameter int unsigned LEDR_W     = 17,
  parameter int unsigned LEDG_W     = 8,
  parameter int unsigned NUM_HEX    = 8,
  parameter int unsigned SW_W       = 18,
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic [7:0]             i_addr,
  input  logic [3:0]             i_be,
  input  logic [31:0]            i_wdata,
  output logic                   o_ack,
  output logic                   o_err,
  output logic [31:0]            o_rdata,
  output logic [LEDR_W-1:0]      o_io_ledr,
  output logic [LEDG_W-1:0]      o_io_ledg,
  output logic [NUM_HEX*7-1:0]   o_io_hex,
  output logic [31:0]            o_io_lcd,
  output logic                   o_sw_irq,
  input  logic [SW_W-1:0]        i_io_sw
);

  // Word indices (byte offset >> 2)
  localparam logic [5:0] A_LEDR = 6'h00;
  localparam logic [5:0] A_LEDG = 6'h01;
  localparam logic [5:0] A_HEX0 = 6'h04;
  localparam logic [5:0] A_HEX1 = 6'h05;
  localparam logic [5:0] A_LCD  = 6'h08;
  localparam logic [5:0] A_SW   = 6'h0C;
  localparam logic [5:0] A_STAT = 6'h0D;

  logic [5:0]      widx;
  logic            mapped;
  logic            err_c;
  logic            wr_en;
  logic            stat_clr;
  logic [31:0]     be_mask;
  logic [31:0]     rd_c;
  logic [63:0]     hex_lanes;
  logic [6:0]      hex_q [NUM_HEX];
  logic [SW_W-1:0] sw_s1;
  logic [SW_W-1:0] sw_s2;
  logic [SW_W-1:0] sw_db;
  logic            sw_chg_c;
  logic            sw_chg;
  logic            unused_ok;

  assign widx      = i_addr[7:2];
  assign unused_ok = ^{i_addr[1:0], DEB_CYCLES[0]};

  // Byte-enable merge of a 32-bit image of a register
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Address decode and error classification
  always_comb begin
    mapped   = 1'b0;
    case (widx)
      A_LEDR, A_LEDG, A_HEX0, A_HEX1, A_LCD, A_SW, A_STAT: mapped = 1'b1;
      default: mapped = 1'b0;
    endcase
    err_c    = !mapped || (i_we && widx == A_SW);
    wr_en    = i_req && i_we && !err_c;
    stat_clr = wr_en && widx == A_STAT && i_be[0] && i_wdata[0];
    be_mask  = {{8{i_be[3]}}, {8{i_be[2]}}, {8{i_be[1]}}, {8{i_be[0]}}};
  end

  // Digits laid out one per byte lane; missing digits read as 0
  always_comb begin
    hex_lanes = '0;
    o_io_hex  = '0;
    for (int k = 0; k < int'(NUM_HEX); k++) begin
      hex_lanes[8*k +: 7] = hex_q[k];
      o_io_hex[7*k +: 7]  = hex_q[k];
    end
  end

  // Read mux on pre-edge register state
  always_comb begin
    rd_c = '0;
    case (widx)
      A_LEDR: rd_c = 32'(o_io_ledr);
      A_LEDG: rd_c = 32'(o_io_ledg);
      A_HEX0: rd_c = hex_lanes[31:0];
      A_HEX1: rd_c = hex_lanes[63:32];
      A_LCD:  rd_c = o_io_lcd;
      A_SW:   rd_c = 32'(sw_db);
      A_STAT: rd_c = {31'b0, o_sw_irq};
      default: rd_c = '0;
    endcase
  end

  // Response and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= '0;
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
      for (int k = 0; k < int'(NUM_HEX); k++) hex_q[k] <= 7'h7F;
    end else begin
      o_ack   <= i_req;
      o_err   <= i_req && err_c;
      o_rdata <= (i_req && !i_we && !err_c) ? rd_c : '0;
      if (wr_en && widx == A_LEDR)
        o_io_ledr <= LEDR_W'(be_merge(32'(o_io_ledr), i_wdata, be_mask));
      if (wr_en && widx == A_LEDG)
        o_io_ledg <= LEDG_W'(be_merge(32'(o_io_ledg), i_wdata, be_mask));
      if (wr_en && widx == A_LCD)
        o_io_lcd <= be_merge(o_io_lcd, i_wdata, be_mask);
      // Digit k lives in byte k%4 of word HEX0 (k<4) or HEX1 (k>=4)
      for (int k = 0; k < int'(NUM_HEX); k++) begin
        if (wr_en && i_be[k % 4] &&
            ((k < 4 && widx == A_HEX0) || (k >= 4 && widx == A_HEX1)))
          hex_q[k] <= i_wdata[8*(k % 4) +: 7];
      end
    end
  end

  // Switch synchroniser, change flag and sticky IRQ (set beats clear)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      sw_chg   <= 1'b0;
      o_sw_irq <= 1'b0;
    end else begin
      sw_s1  <= i_io_sw;
      sw_s2  <= sw_s1;
      sw_chg <= sw_chg_c;
      if (sw_chg)
        o_sw_irq <= 1'b1;
      else if (stat_clr)
        o_sw_irq <= 1'b0;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [SW_W-1:0]  sw_s3;
  logic [CNT_W-1:0] deb_cnt;
  logic             load_c;

  // Load once the synchronised value has differed from sw_db and stayed put
  // for DEB_CYCLES cycles; deb_cnt counts the steady cycles seen so far.
  assign load_c   = (sw_s2 != sw_db) && (sw_s2 == sw_s3) &&
                    (deb_cnt == CNT_W'(DEB_CYCLES - 1));
  assign sw_chg_c = load_c;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_s3   <= '0;
      deb_cnt <= '0;
      sw_db   <= '0;
    end else begin
      sw_s3 <= sw_s2;
      if (sw_s2 == sw_db) begin
        deb_cnt <= '0;
      end else if (sw_s2 != sw_s3) begin
        deb_cnt <= CNT_W'(1);
      end else if (load_c) begin
        sw_db   <= sw_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign sw_chg_c = (sw_s2 != sw_db);

  // Debounced register is simply the synchronised value, one stage later
  always_ff @(posedge i_clk) begin
    if (i_reset) sw_db <= '0;
    else         sw_db <= sw_s2;
  end
`endif

endmodule
